// File: rtl/apb_completer.sv
// APB completer with a small register file: live status, a privileged CTRL
// register, five scratch words and a completed-transfer counter.
module apb_completer #(
  parameter int DATAWIDTH   = 32,
  parameter int ADDRWIDTH   = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [ADDRWIDTH-1:0] paddr,
  input  logic [DATAWIDTH-1:0] pwdata,
  input  logic [3:0]           pstrb,
  input  logic [2:0]           pprot,
  input  logic [31:0]          status_in,
  output logic [DATAWIDTH-1:0] prdata,
  output logic                 pready,
  output logic                 pslverr,
  output logic [31:0]          ctrl_out
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_next;

  logic [ADDRWIDTH-1:0] r_addr;
  logic                 r_write;
  logic [DATAWIDTH-1:0] r_wdata;
  logic [3:0]           r_strb;
  logic                 r_priv;

  logic [31:0]          r_regs [1:6];
  logic [15:0]          r_xfer;

  logic                 w_setup;
  logic                 w_ready;
  logic                 w_complete;
  logic [2:0]           w_idx;
  logic                 w_err;
  logic [31:0]          w_rd_val;
  logic                 w_unused;

  assign w_unused   = &{1'b0, pprot[2:1]};
  assign w_setup    = psel & ~penable;
  assign w_ready    = (r_state == S_ACCESS) && (r_cnt == 4'd0);
  assign w_complete = w_ready & psel & penable;
  assign w_idx      = r_addr[4:2];

  // Error decode uses only the values captured in the setup phase.
  assign w_err = (r_addr[1:0] != 2'b00)
               | (r_addr >= ADDRWIDTH'(32))
               | (r_write & ((w_idx == 3'd0) | (w_idx == 3'd7)))
               | (r_write & (w_idx == 3'd1) & ~r_priv);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_setup) begin
          w_state_next = S_ACCESS;
          w_cnt_next   = 4'(WAIT_CYCLES);
        end
      end
      S_ACCESS: begin
        if (!psel || w_complete) begin
          w_state_next = S_IDLE;
        end else if (penable && (r_cnt != 4'd0)) begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && w_setup) begin
      r_addr  <= paddr;
      r_write <= pwrite;
      r_wdata <= pwdata;
      r_strb  <= pstrb;
      r_priv  <= pprot[0];
    end
  end

  // Register file and transfer counter; only a completing edge changes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= 6; i++) r_regs[i] <= 32'd0;
      r_xfer <= 16'd0;
    end else if (w_complete) begin
      r_xfer <= r_xfer + 16'd1;
      if (r_write && !w_err) begin
        for (int i = 1; i <= 6; i++) begin
          if (w_idx == 3'(i)) begin
            for (int b = 0; b < 4; b++) begin
              if (r_strb[b]) r_regs[i][8*b +: 8] <= r_wdata[8*b +: 8];
            end
          end
        end
      end
    end
  end

  always_comb begin
    w_rd_val = 32'd0;
    case (w_idx)
      3'd0:    w_rd_val = status_in;
      3'd1:    w_rd_val = r_regs[1];
      3'd2:    w_rd_val = r_regs[2];
      3'd3:    w_rd_val = r_regs[3];
      3'd4:    w_rd_val = r_regs[4];
      3'd5:    w_rd_val = r_regs[5];
      3'd6:    w_rd_val = r_regs[6];
      default: w_rd_val = {16'd0, r_xfer};
    endcase
  end

  assign pready   = w_ready;
  assign pslverr  = w_ready & w_err;
  assign prdata   = (w_complete && !r_write && !w_err) ? DATAWIDTH'(w_rd_val) : '0;
  assign ctrl_out = r_regs[1];

endmodule

// File: tb/tb_apb_completer.sv
// Randomized and directed bench for apb_completer against a behavioural
// register-map model; a second zero-wait instance exercises back-to-back reads.
module tb_apb_completer;

  localparam int WAITS = 2;
  localparam int N_B2B = 3000;

  logic        clk;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, status_in, prdata, ctrl_out;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready, pslverr;

  logic        b_psel, b_penable;
  logic [31:0] b_paddr, b_prdata, b_ctrl_out;
  logic        b_pready, b_pslverr;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_regs [0:7];
  logic [15:0] m_xfer;

  apb_completer #(.DATAWIDTH(32), .ADDRWIDTH(32), .WAIT_CYCLES(WAITS)) u_dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .status_in(status_in), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .ctrl_out(ctrl_out)
  );

  apb_completer #(.DATAWIDTH(32), .ADDRWIDTH(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .psel(b_psel), .penable(b_penable), .pwrite(1'b0),
    .paddr(b_paddr), .pwdata(32'd0), .pstrb(4'd0), .pprot(3'd0),
    .status_in(32'd0), .prdata(b_prdata), .pready(b_pready),
    .pslverr(b_pslverr), .ctrl_out(b_ctrl_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one APB transfer starting just after a rising edge; returns
  // just after the completing edge with the bus idle.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot,
                          output logic [31:0] rdata, output logic err, output int waits);
    bit done = 0;
    psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb; pprot = prot;
    @(posedge clk); #1;
    penable = 1;
    pwdata = $urandom;
    pstrb  = 4'($urandom);
    paddr  = $urandom;
    waits = 0; rdata = 32'd0; err = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (pready) begin
        rdata = prdata; err = pslverr; done = 1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    if (!done) check_eq("timeout", 32'd0, 32'd1);
    psel = 0; penable = 0;
  endtask

  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [2:0] prot,
                         output logic [31:0] rdata, output logic err);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          idx;
    int          waits;
    idx = int'(addr[4:2]);
    exp_err = (addr % 4 != 0) || (addr >= 32) || (wr && (idx == 0 || idx == 7))
              || (wr && idx == 1 && !prot[0]);
    if (wr || exp_err)  exp_rd = 32'd0;
    else if (idx == 0)  exp_rd = status_in;
    else if (idx == 7)  exp_rd = {16'd0, m_xfer};
    else                exp_rd = m_regs[idx];
    apb_xfer(wr, addr, wdata, strb, prot, rdata, err, waits);
    check_eq("waits", waits, WAITS);
    check_eq("pslverr", {31'd0, err}, {31'd0, exp_err});
    check_eq("prdata", rdata, exp_rd);
    if (wr && !exp_err)
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_regs[idx][8*b +: 8] = wdata[8*b +: 8];
    m_xfer = m_xfer + 16'd1;
    check_eq("ctrl_out", ctrl_out, m_regs[1]);
    check_eq("idle_pready", {31'd0, pready}, 32'd0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
    m_xfer = 16'd0;
  endtask

  initial begin
    logic [31:0] rd, cnt0, addr;
    logic        er;
    int          idx;

    rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    pstrb = 0; pprot = 0; status_in = 32'hC0FFEE01;
    b_psel = 0; b_penable = 0; b_paddr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_pready", {31'd0, pready}, 32'd0);
    check_eq("rst_pslverr", {31'd0, pslverr}, 32'd0);
    check_eq("rst_prdata", prdata, 32'd0);
    check_eq("rst_ctrl", ctrl_out, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check_eq("post_rst_pready", {31'd0, pready}, 32'd0);
    @(posedge clk); #1;

    do_xfer(1, 32'h04, 32'hDEADBEEF, 4'hF, 3'b001, rd, er);
    check_eq("ctrl_deadbeef", ctrl_out, 32'hDEADBEEF);

    do_xfer(1, 32'h08, 32'hAAAAAAAA, 4'hF, 3'b000, rd, er);
    do_xfer(1, 32'h08, 32'h12345678, 4'h3, 3'b000, rd, er);
    do_xfer(0, 32'h08, 32'd0, 4'h0, 3'b000, rd, er);
    check_eq("strb_merge", rd, 32'hAAAA5678);

    do_xfer(0, 32'h1C, 32'd0, 4'h0, 3'b000, cnt0, er);
    do_xfer(1, 32'h04, 32'h11111111, 4'hF, 3'b000, rd, er);
    check_eq("unpriv_err", {31'd0, er}, 32'd1);
    do_xfer(1, 32'h00, 32'h22222222, 4'hF, 3'b001, rd, er);
    check_eq("ro_err", {31'd0, er}, 32'd1);
    check_eq("ctrl_kept", ctrl_out, 32'hDEADBEEF);
    do_xfer(0, 32'h00, 32'd0, 4'h0, 3'b000, rd, er);
    check_eq("status_kept", rd, 32'hC0FFEE01);
    do_xfer(0, 32'h1C, 32'd0, 4'h0, 3'b000, rd, er);
    check_eq("cnt_plus", rd, cnt0 + 32'd4);

    do_xfer(0, 32'h20, 32'd0, 4'h0, 3'b000, rd, er);
    check_eq("rd20_err", {31'd0, er}, 32'd1);
    do_xfer(0, 32'h06, 32'd0, 4'h0, 3'b000, rd, er);
    check_eq("rd06_err", {31'd0, er}, 32'd1);

    // Abort after one access cycle of a write to 0x0C.
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h0C; pwdata = 32'h0BADF00D; pstrb = 4'hF; pprot = 3'b001;
    @(posedge clk); #1;
    penable = 1;
    @(negedge clk);
    check_eq("abort_nrdy1", {31'd0, pready}, 32'd0);
    @(posedge clk); #1;
    psel = 0; penable = 0;
    @(negedge clk);
    check_eq("abort_nrdy2", {31'd0, pready}, 32'd0);
    @(posedge clk); #1;
    do_xfer(0, 32'h0C, 32'd0, 4'h0, 3'b000, rd, er);
    do_xfer(0, 32'h1C, 32'd0, 4'h0, 3'b000, rd, er);

    // Enable without a setup phase must be ignored.
    psel = 1; penable = 1; pwrite = 1; paddr = 32'h10; pwdata = 32'h77777777; pstrb = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("nosetup_pready", {31'd0, pready}, 32'd0);
      @(posedge clk); #1;
    end
    psel = 0; penable = 0;
    do_xfer(0, 32'h10, 32'd0, 4'h0, 3'b000, rd, er);
    do_xfer(0, 32'h1C, 32'd0, 4'h0, 3'b000, rd, er);

    for (int t = 0; t < 300; t++) begin
      idx  = $urandom_range(0, 7);
      addr = 32'(idx * 4);
      if ($urandom_range(0, 9) == 0) addr = addr + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 14) == 0) addr = addr + 32'h20 * 32'($urandom_range(1, 100));
      status_in = $urandom;
      do_xfer(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom), 3'($urandom), rd, er);
    end

    // Reset in the middle of a CTRL write drops it.
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h04; pwdata = 32'h5A5A5A5A; pstrb = 4'hF; pprot = 3'b001;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    rst = 1; psel = 0; penable = 0;
    @(negedge clk);
    check_eq("midrst_pready", {31'd0, pready}, 32'd0);
    check_eq("midrst_prdata", prdata, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    check_eq("midrst_ctrl", ctrl_out, 32'd0);
    model_reset();
    do_xfer(0, 32'h04, 32'd0, 4'h0, 3'b000, rd, er);
    do_xfer(0, 32'h1C, 32'd0, 4'h0, 3'b000, rd, er);
    do_xfer(0, 32'h18, 32'd0, 4'h0, 3'b000, rd, er);

    // Zero-wait instance: back-to-back counter reads, two cycles each.
    b_paddr = 32'h1C;
    for (int i = 0; i < N_B2B; i++) begin
      b_psel = 1; b_penable = 0;
      @(posedge clk); #1;
      b_penable = 1;
      @(negedge clk);
      check_eq("b2b_pready", {31'd0, b_pready}, 32'd1);
      check_eq("b2b_prdata", b_prdata, 32'(i));
      @(posedge clk); #1;
    end
    b_psel = 0; b_penable = 0;
    @(negedge clk);
    check_eq("b2b_idle", {31'd0, b_pready}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_completer.md
APB_COMPLETER -- requirements
Module: apb_completer

Interface
REQ-001 Parameter DATAWIDTH, default 32: PWDATA/PRDATA width; only 32 is supported.
REQ-002 Parameter ADDRWIDTH, default 32: PADDR width.
REQ-003 Parameter WAIT_CYCLES, default 2: pready=0 cycles inserted per transfer, range 0..15.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port psel / penable / pwrite, input, 1 each: APB select, enable and direction (1=write).
REQ-007 Port paddr, input, ADDRWIDTH: byte address.
REQ-008 Port pwdata, input, DATAWIDTH: write data.
REQ-009 Port pstrb, input, 4: byte-lane write strobes.
REQ-010 Port pprot, input, 3: protection; bit0=1 privileged.
REQ-011 Port status_in, input, 32: hardware status, read-only at register 0.
REQ-012 Port prdata, output, DATAWIDTH: read data.
REQ-013 Port pready / pslverr, output, 1 each: transfer complete / transfer error.
REQ-014 Port ctrl_out, output, 32: current contents of register 1.

Function
REQ-015 Map (word index = paddr[4:2]): 0 = status_in (RO); 1 = CTRL (RW, privileged write only); 2..6 = RW scratch; 7 = XFER_CNT (RO, 16-bit, zero-extended).
REQ-016 FSM states: IDLE and ACCESS.
REQ-017 IDLE: psel=1 and penable=0 -> ACCESS; latch paddr, pwrite, pwdata, pstrb, pprot; load wait counter with WAIT_CYCLES.
REQ-018 IDLE with psel=0, or with psel=1 and penable=1 (no setup phase): stay IDLE; pready=0; no side effects.
REQ-019 ACCESS: pready = (wait counter == 0); pready is decoded from registered state only, never combinationally from inputs.
REQ-020 ACCESS: each cycle with psel&penable=1 and counter != 0 decrements the counter by 1.
REQ-021 ACCESS: psel&penable&pready=1 completes the transfer at that edge, then -> IDLE; a new setup may follow in the next cycle (back-to-back).
REQ-022 ACCESS with psel=0 (abort): -> IDLE next edge; no register write; XFER_CNT unchanged.
REQ-023 WAIT_CYCLES=0: pready=1 in the first access cycle, giving a 2-cycle transfer.
REQ-024 Error conditions, decoded from latched values: paddr[1:0] != 0; paddr >= 32; write to index 0 or 7; write to index 1 with pprot[0]=0.
REQ-025 pslverr = pready AND error; pslverr=0 whenever pready=0.
REQ-026 On an error transfer, no register is modified and prdata=0.
REQ-027 Write completion without error: for each i with pstrb[i]=1, update byte i of the target register from the latched pwdata; lanes with pstrb[i]=0 keep their value.
REQ-028 Read completion without error: prdata = selected register value; pstrb ignored.
REQ-029 Outside a read-completion cycle, prdata=0.
REQ-030 XFER_CNT increments by 1, wrapping 0xFFFF->0x0000, on every completed transfer (read, write, ok or error); aborts do not count.
REQ-031 A read of XFER_CNT returns the value before that transfer's increment.
REQ-032 Latched pwdata is used for the write even if pwdata changes during wait states.
REQ-033 ctrl_out reflects a CTRL write from the cycle after the completing edge.

Reset
REQ-034 rst=1 at a clock edge: state=IDLE, wait counter=0, registers 1..6=0, XFER_CNT=0.
REQ-035 During and after reset, until the next completion: pready=0, pslverr=0, prdata=0, ctrl_out=0.
REQ-036 rst asserted mid-transfer: the transfer is dropped with no write and no pready; the requester must restart from a setup phase.

Verification
REQ-037 WAIT_CYCLES=2, privileged write 0xDEADBEEF to 0x04 with pstrb=0xF -> pready=0 for 2 access cycles, then 1 with pslverr=0; next cycle ctrl_out=0xDEADBEEF.
REQ-038 pstrb=0x3, write 0x12345678 to 0x08 over 0xAAAAAAAA -> read of 0x08 returns 0xAAAA5678.
REQ-039 Write to 0x04 with pprot=3'b000; separately, write to 0x00 -> each gives pslverr=1 with pready; ctrl_out and status unchanged; XFER_CNT increases by 2.
REQ-040 Read of 0x20, and read of 0x06 -> pslverr=1, prdata=0.
REQ-041 Abort: psel dropped after 1 access cycle of a write to 0x0C -> no pready; 0x0C unchanged; XFER_CNT unchanged.
REQ-042 WAIT_CYCLES=0, 65536 back-to-back reads of 0x1C -> each completes in 2 cycles; the last returns 0xFFFF and the next returns 0x0000.
